// File: rtl/if_id_fetch_stage_pkg.sv
// ============================================================================
// Module : if_id_fetch_stage_pkg
// Brief  : Shared fetch-pipeline constants, FSM encoding and helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package if_id_fetch_stage_pkg;

    localparam logic [31:0] c_nop_instr          = 32'h0000_0013;
    localparam logic [31:0] c_reset_vector       = 32'h0000_0000;
    localparam logic [31:0] c_word_mask          = 32'hFFFF_FFFC;
    localparam logic [31:0] c_instr_bytes        = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & c_word_mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_hold_buffer.sv
// ============================================================================
// Module : if_id_hold_buffer
// Brief  : One-entry skid buffer for a fetched word arriving during a stall.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module if_id_hold_buffer
    import if_id_fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    // Clear wins so a redirect can never leave a stale entry behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= 32'h0000_0000;
            r_instr <= c_nop_instr;
        end else if (clear) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_pc    <= load_pc;
            r_instr <= load_instr;
        end
    end

    assign valid = r_valid;
    assign pc    = r_pc;
    assign instr = r_instr;

endmodule

`default_nettype wire

// File: rtl/if_id_fetch_stage.sv
// ============================================================================
// Module : if_id_fetch_stage
// Brief  : Instruction fetch FSM feeding the IF/ID pipeline register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module if_id_fetch_stage
    import if_id_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = c_reset_vector
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_gate,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_instr,
    output logic        IF_ID_valid,
    output logic [4:0]  IF_ID_rs1,
    output logic [4:0]  IF_ID_rs2
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_discard;
    logic [31:0]  r_if_id_pc;
    logic [31:0]  r_if_id_instr;
    logic         r_if_id_valid;

    logic         w_buf_valid;
    logic [31:0]  w_buf_pc;
    logic [31:0]  w_buf_instr;
    logic         w_buf_load;
    logic         w_buf_clear;
    logic         w_deliver;
    logic         w_in_flight;

    assign w_deliver   = (r_state == S_WAIT) && imem_rvalid && !r_discard;
    // A request is still owed a response when redirected from these points.
    assign w_in_flight = (r_state == S_REQ) || ((r_state == S_WAIT) && !imem_rvalid);
    assign w_buf_load  = w_deliver && !clk_gate && !branch_taken;
    assign w_buf_clear = branch_taken || ((r_state == S_HOLD) && clk_gate);

    if_id_hold_buffer u_hold_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_buf_load),
        .clear      (w_buf_clear),
        .load_pc    (r_pc),
        .load_instr (imem_rdata),
        .valid      (w_buf_valid),
        .pc         (w_buf_pc),
        .instr      (w_buf_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_VECTOR;
            r_discard     <= 1'b0;
            r_if_id_pc    <= 32'h0000_0000;
            r_if_id_instr <= c_nop_instr;
            r_if_id_valid <= 1'b0;
        end else if (branch_taken) begin
            r_pc          <= word_align(branch_target);
            r_if_id_instr <= c_nop_instr;
            r_if_id_valid <= 1'b0;
            r_discard     <= w_in_flight;
            r_state       <= w_in_flight ? S_WAIT : S_REQ;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ:  r_state <= S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_discard) begin
                            r_discard <= 1'b0;
                            r_state   <= S_REQ;
                        end else if (clk_gate) begin
                            r_pc    <= r_pc + c_instr_bytes;
                            r_state <= S_REQ;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (clk_gate) begin
                        r_pc    <= r_pc + c_instr_bytes;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (clk_gate) begin
                if (w_deliver) begin
                    r_if_id_pc    <= r_pc;
                    r_if_id_instr <= imem_rdata;
                    r_if_id_valid <= 1'b1;
                end else if ((r_state == S_HOLD) && w_buf_valid) begin
                    r_if_id_pc    <= w_buf_pc;
                    r_if_id_instr <= w_buf_instr;
                    r_if_id_valid <= 1'b1;
                end else begin
                    r_if_id_instr <= c_nop_instr;
                    r_if_id_valid <= 1'b0;
                end
            end
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign IF_ID_pc    = r_if_id_pc;
    assign IF_ID_instr = r_if_id_instr;
    assign IF_ID_valid = r_if_id_valid;
    assign IF_ID_rs1   = r_if_id_instr[19:15];
    assign IF_ID_rs2   = r_if_id_instr[24:20];

endmodule

`default_nettype wire

// File: doc/if_id_fetch_stage.md
IF_ID_FETCH_STAGE -- requirements
Module: if_id_fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the PC value loaded at reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clk_gate, input, 1, pipeline advance enable from stall detection: 1=advance, 0=hold.
REQ-005 The block SHALL have port branch_taken, input, 1, redirect/flush request from EX.
REQ-006 The block SHALL have port branch_target, input, 32, the redirect PC; bits [1:0] are ignored and treated as 00.
REQ-007 The block SHALL have port imem_req, output, 1, a one-cycle instruction fetch request pulse.
REQ-008 The block SHALL have port imem_addr, output, 32, the fetch address, valid while imem_req=1.
REQ-009 The block SHALL have port imem_rdata, input, 32, the returned instruction word.
REQ-010 The block SHALL have port imem_rvalid, input, 1, response strobe; arrives >=1 cycle after imem_req.
REQ-011 The block SHALL have ports IF_ID_pc, output, 32, and IF_ID_instr, output, 32, the IF/ID register contents.
REQ-012 The block SHALL have port IF_ID_valid, output, 1; 0 marks a bubble.
REQ-013 The block SHALL have ports IF_ID_rs1 and IF_ID_rs2, output, 5 each, equal to IF_ID_instr[19:15] and [24:20] combinationally.

Function
REQ-014 The block SHALL keep at most one imem request outstanding.
REQ-015 The FSM SHALL have states S_IDLE, S_REQ, S_WAIT and S_HOLD.
REQ-016 S_IDLE SHALL go to S_REQ on the first clock after reset release.
REQ-017 S_REQ SHALL drive imem_req=1 with imem_addr=pc, then go to S_WAIT.
REQ-018 In S_WAIT, imem_rvalid=1 with clk_gate=1 SHALL load IF/ID with {pc, rdata, valid=1}, set pc<=pc+4 (mod 2^32 wrap), and go to S_REQ.
REQ-019 In S_WAIT, imem_rvalid=1 with clk_gate=0 SHALL capture {pc, rdata} in a one-entry hold buffer and go to S_HOLD; IF/ID holds.
REQ-020 In S_HOLD, clk_gate=1 SHALL move the buffer into IF/ID with valid=1, set pc<=pc+4, and go to S_REQ.
REQ-021 While clk_gate=0, IF_ID_pc, IF_ID_instr and IF_ID_valid SHALL hold their values.
REQ-022 While clk_gate=1 and no instruction is delivered that cycle, IF/ID SHALL load a bubble: instr=32'h0000_0013 (NOP), valid=0, pc unchanged.
REQ-023 branch_taken=1 SHALL take priority over clk_gate and respond as follows:
- pc<=target
- IF/ID<=bubble
- hold buffer cleared
REQ-024 On a branch in S_REQ or in S_WAIT without a same-cycle rvalid, the block SHALL set a discard flag, drop the next response, then go to S_REQ.
REQ-025 On a branch coincident with rvalid in S_WAIT, the block SHALL drop that response and go directly to S_REQ.
REQ-026 On a branch in S_HOLD or S_IDLE, the block SHALL go to S_REQ.
REQ-027 A discarded response SHALL never reach IF/ID or change pc.

Reset
REQ-028 rst_n=0 SHALL asynchronously force the following, with no imem transaction issued during reset:
- pc=RESET_VECTOR
- state=S_IDLE
- imem_req=0
- imem_addr=RESET_VECTOR
- IF_ID_pc=0
- IF_ID_instr=32'h0000_0013
- IF_ID_valid=0
- discard=0
- buffer empty
REQ-029 Reset mid-request SHALL abandon the outstanding request, and the first post-reset response SHALL be treated as the new fetch's response.

Structure
REQ-030 The shared pipeline package SHALL hold the NOP constant 32'h0000_0013, the fetch state encoding, and the default RESET_VECTOR.
REQ-031 The one-entry hold buffer SHALL be a sub-module named if_id_hold_buffer (load, clear, valid, pc, instr).

Verification
REQ-032 Reset release, 1-cycle memory, clk_gate=1 -> imem_addr 0x0,0x4,0x8 on successive requests; IF_ID_pc follows with valid=1.
REQ-033 clk_gate=0 for 3 cycles while rvalid returns instr 0x00A00093 at pc 0x8 -> IF/ID holds the prior instr; on clk_gate=1, IF_ID_instr=0x00A00093, rs1=0, next request address=0xC.
REQ-034 branch_taken=1 with target 0x103 in S_WAIT, rvalid 2 cycles later -> response dropped, IF_ID_valid=0, next imem_addr=0x100.
REQ-035 branch_taken=1 coincident with rvalid and clk_gate=0 -> branch wins, response dropped, next imem_addr=branch_target.
REQ-036 pc=0xFFFF_FFFC fetch completes -> next imem_addr=0x0000_0000.
REQ-037 rst_n low mid-S_WAIT -> all outputs reach reset values immediately; first request after release targets RESET_VECTOR.
